serial_twos_comp: RTL

Parametrised bit-serial two's-complement unit for the serial arithmetic datapath. It accepts LSB-first words of `W` bits with a start-of-word marker. Per word, it either passes the word through or negates it using the copy-until-first-one / invert-thereafter rule. Compared with the fixed single-word complementer, it adds:
- word framing;
- a per-word mode;
- a registered output with valid/eof strobes;
- overflow and framing-error reporting.

---
 rtl/serial_twos_comp_if.sv | 24 ++
 rtl/serial_twos_comp.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_twos_comp_if.sv
// Bit-serial stream bundle for serial_twos_comp: input beat with framing/mode,
// registered output beat with framing and error strobes.
interface serial_twos_comp_if;
    logic in_valid;
    logic in_bit;
    logic in_sof;
    logic neg;
    logic out_valid;
    logic out_bit;
    logic out_sof;
    logic out_eof;
    logic ovf;
    logic frame_err;

    modport master (
        output in_valid, in_bit, in_sof, neg,
        input  out_valid, out_bit, out_sof, out_eof, ovf, frame_err
    );

    modport slave (
        input  in_valid, in_bit, in_sof, neg,
        output out_valid, out_bit, out_sof, out_eof, ovf, frame_err
    );
endinterface

// File: rtl/serial_twos_comp.sv
// Framed bit-serial two's-complement unit: per word, pass through or negate LSB-first
// using copy-until-first-one / invert-thereafter, with registered outputs.
module serial_twos_comp #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W)
) (
    input logic               clk,
    input logic               reset,
    serial_twos_comp_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCopy, StInv} state_e;

    localparam logic [CW-1:0] LastIdx = CW'(W - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          neg_q, neg_d;
    logic          out_valid_q, out_valid_d;
    logic          out_bit_q, out_bit_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eof_q, out_eof_d;
    logic          ovf_q, ovf_d;
    logic          frame_err_q, frame_err_d;

    state_e        cur_state;
    logic [CW-1:0] cur_idx;
    logic          cur_neg;
    logic          accept;
    logic          last;
    logic          first_one;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        neg_d       = neg_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        ovf_d       = 1'b0;
        frame_err_d = 1'b0;
        cur_state   = state_q;
        cur_idx     = idx_q;
        cur_neg     = neg_q;
        accept      = 1'b0;
        last        = 1'b0;
        first_one   = 1'b0;

        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // sof always restarts framing; a word still in flight is abandoned
                cur_state   = StCopy;
                cur_idx     = '0;
                cur_neg     = bus.neg;
                neg_d       = bus.neg;
                frame_err_d = (state_q != StIdle);
                accept      = 1'b1;
            end else if (state_q == StIdle) begin
                frame_err_d = 1'b1;
            end else begin
                accept = 1'b1;
            end
        end

        if (accept) begin
            last        = (cur_idx == LastIdx);
            first_one   = cur_neg && (cur_state == StCopy) && bus.in_bit;
            out_valid_d = 1'b1;
            out_bit_d   = bus.in_bit ^ (cur_neg && (cur_state == StInv));
            out_sof_d   = (cur_idx == '0);
            out_eof_d   = last;
            if (last) begin
                state_d = StIdle;
                idx_d   = '0;
                // still copying at a set MSB means the word was 1 followed by zeros
                ovf_d   = first_one;
            end else begin
                idx_d   = cur_idx + CW'(1);
                state_d = first_one ? StInv : cur_state;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            ovf_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            ovf_q       <= ovf_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.ovf       = ovf_q;
    assign bus.frame_err = frame_err_q;
endmodule
